bfs_multi: RTL

- Parametrised breadth-first-search engine over a CSR graph held in on-chip arrays.
- Host loads node ranges and edge destinations, pulses start, then reads back the per-level histogram (level_counts) and the per-node level array.
- Generalises the fixed 16-node/64-edge BFS engine to arbitrary power-of-two graph sizes and level depths.
- Adds abort, per-node level readback, write lockout while busy, and a safe policy for malformed edge ranges.

---
 rtl/bfs_multi.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bfs_multi.sv
// Breadth-first-search engine over a CSR graph held in on-chip arrays, with
// abort, per-node level readback and write lockout. Optional cycle counter: BFS_MULTI_CYCLE_CNT_EN.
module bfs_multi #(
  parameter  int SCALE       = 4,
  parameter  int EDGE_FACTOR = 4,
  parameter  int N_LEVELS    = 10,
  parameter  int LEVEL_W     = 8,
  parameter  int CNT_W       = SCALE + 1,
  localparam int N_NODES     = 2**SCALE,
  localparam int N_EDGES     = N_NODES * EDGE_FACTOR,
  localparam int EW          = $clog2(N_EDGES),
  localparam int LCA_W       = $clog2(N_LEVELS),
  localparam int LU_W        = LCA_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               node_we,
  input  logic [SCALE-1:0]   node_waddr,
  input  logic [EW:0]        node_begin_wdata,
  input  logic [EW:0]        node_end_wdata,
  input  logic               edge_we,
  input  logic [EW-1:0]      edge_waddr,
  input  logic [SCALE-1:0]   edge_dst_wdata,
  input  logic               start,
  input  logic               abort,
  input  logic [SCALE-1:0]   start_node,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [LU_W-1:0]    levels_used,
  input  logic [LCA_W-1:0]   lc_rd_addr,
  output logic [CNT_W-1:0]   lc_rd_data,
  input  logic [SCALE-1:0]   lv_rd_addr,
  output logic [LEVEL_W-1:0] lv_rd_data
`ifdef BFS_MULTI_CYCLE_CNT_EN
  ,
  output logic [31:0]        cycle_cnt
`endif
);

  localparam int INIT_N = (N_NODES > N_LEVELS) ? N_NODES : N_LEVELS;
  localparam int IW     = $clog2(INIT_N) + 1;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_ROOT, S_H_START, S_NODE_LD, S_NODE_DEC,
    S_EDGE_LD, S_EDGE_DEC, S_POST, S_FIN
  } state_t;

  logic [EW:0]        node_begin   [N_NODES];
  logic [EW:0]        node_end     [N_NODES];
  logic [SCALE-1:0]   edge_dst     [N_EDGES];
  logic [LEVEL_W-1:0] level        [N_NODES];
  logic [CNT_W-1:0]   level_counts [N_LEVELS];

  state_t             state_q, state_d;
  logic [SCALE-1:0]   root_q, root_d, n_q, n_d, dst_q, dst_d;
  logic [IW-1:0]      init_q, init_d;
  logic [LEVEL_W-1:0] h_q, h_d, lvn_q, lvn_d, hp1;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EW:0]        e_q, e_d, end_q, end_d;
  logic [LU_W-1:0]    lu_q, lu_d;
  logic               busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic               abort_hit, dst_unvisited;

  logic               lv_we, lc_we;
  logic [SCALE-1:0]   lv_wa;
  logic [LEVEL_W-1:0] lv_wd;
  logic [LCA_W-1:0]   lc_wa;
  logic [CNT_W-1:0]   lc_wd;

`ifdef BFS_MULTI_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  assign cycle_cnt = cyc_q;
`endif

  assign hp1           = h_q + LEVEL_W'(1);
  assign abort_hit     = abort && (state_q != S_IDLE) && (state_q != S_FIN);
  assign dst_unvisited = (level[dst_q] == MAX_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      root_q    <= '0;
      n_q       <= '0;
      dst_q     <= '0;
      init_q    <= '0;
      h_q       <= '0;
      lvn_q     <= '0;
      cnt_q     <= '0;
      e_q       <= '0;
      end_q     <= '0;
      lu_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef BFS_MULTI_CYCLE_CNT_EN
      cyc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      root_q    <= root_d;
      n_q       <= n_d;
      dst_q     <= dst_d;
      init_q    <= init_d;
      h_q       <= h_d;
      lvn_q     <= lvn_d;
      cnt_q     <= cnt_d;
      e_q       <= e_d;
      end_q     <= end_d;
      lu_q      <= lu_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
`ifdef BFS_MULTI_CYCLE_CNT_EN
      cyc_q     <= cyc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    root_d    = root_q;
    n_d       = n_q;
    dst_d     = dst_q;
    init_d    = init_q;
    h_d       = h_q;
    lvn_d     = lvn_q;
    cnt_d     = cnt_q;
    e_d       = e_q;
    end_d     = end_q;
    lu_d      = lu_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef BFS_MULTI_CYCLE_CNT_EN
    cyc_d = (busy_q && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        root_d  = start_node;
        init_d  = '0;
        state_d = S_INIT;
`ifdef BFS_MULTI_CYCLE_CNT_EN
        cyc_d   = '0;
`endif
      end
      S_INIT: begin
        if (init_q == IW'(INIT_N - 1)) state_d = S_ROOT;
        else                           init_d  = init_q + IW'(1);
      end
      S_ROOT: begin
        h_d     = '0;
        state_d = S_H_START;
      end
      S_H_START: begin
        cnt_d   = '0;
        n_d     = '0;
        state_d = S_NODE_LD;
      end
      S_NODE_LD: begin
        lvn_d   = level[n_q];
        e_d     = node_begin[n_q];
        end_d   = node_end[n_q];
        state_d = S_NODE_DEC;
      end
      S_NODE_DEC, S_EDGE_LD: begin
        // A frontier node with e < end has edges left; anything else moves to the next node.
        if (state_q == S_NODE_DEC ? (lvn_q == h_q) : (e_q < end_q)) begin
          dst_d   = edge_dst[e_q[EW-1:0]];
          state_d = (state_q == S_NODE_DEC) ? S_EDGE_LD : S_EDGE_DEC;
        end else if (n_q == SCALE'(N_NODES - 1)) begin
          state_d = S_POST;
        end else begin
          n_d     = n_q + SCALE'(1);
          state_d = S_NODE_LD;
        end
      end
      S_EDGE_DEC: begin
        if (dst_unvisited && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        e_d     = e_q + (EW+1)'(1);
        state_d = S_EDGE_LD;
      end
      S_POST: begin
        lu_d = LU_W'(hp1);
        if (cnt_q == '0 || hp1 == LEVEL_W'(N_LEVELS - 1)) begin
          state_d = S_FIN;
        end else begin
          h_d     = hp1;
          state_d = S_H_START;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      lu_d      = lu_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    lv_we = 1'b0;
    lv_wa = '0;
    lv_wd = MAX_LEVEL;
    lc_we = 1'b0;
    lc_wa = '0;
    lc_wd = '0;
    case (state_q)
      S_INIT: begin
        lv_we = (init_q < IW'(N_NODES));
        lv_wa = init_q[SCALE-1:0];
        lc_we = (init_q < IW'(N_LEVELS));
        lc_wa = init_q[LCA_W-1:0];
      end
      S_ROOT: begin
        lv_we = 1'b1;
        lv_wa = root_q;
        lv_wd = '0;
        lc_we = 1'b1;
        lc_wd = CNT_W'(1);
      end
      S_EDGE_DEC: begin
        lv_we = dst_unvisited;
        lv_wa = dst_q;
        lv_wd = hp1;
      end
      S_POST: begin
        lc_we = 1'b1;
        lc_wa = hp1[LCA_W-1:0];
        lc_wd = cnt_q;
      end
      default: ;
    endcase
    if (abort_hit) begin
      lv_we = 1'b0;
      lc_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (node_we && !busy_q) begin
      node_begin[node_waddr] <= node_begin_wdata;
      node_end[node_waddr]   <= node_end_wdata;
    end
    if (edge_we && !busy_q) edge_dst[edge_waddr] <= edge_dst_wdata;
    if (lv_we) level[lv_wa] <= lv_wd;
    if (lc_we) level_counts[lc_wa] <= lc_wd;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign levels_used = lu_q;
  assign lc_rd_data  = (32'(lc_rd_addr) < N_LEVELS) ? level_counts[lc_rd_addr] : '0;
  assign lv_rd_data  = level[lv_rd_addr];

endmodule
